// File: rtl/pwm_tone_sequencer.sv
// pwm_tone_sequencer: plays a table of (posT code, duration) entries into the
// sine-PWM generator, with one-shot/loop playback, end address and abort.
module pwm_tone_sequencer #(
    parameter int AW       = 4,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [3:0]       wr_code,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [AW-1:0]    last_addr,
    output logic [3:0]       pos_t,
    output logic             pwm_en,
    output logic             busy,
    output logic [AW-1:0]    step_addr,
    output logic             done
);
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    state_t           state, state_nxt;
    logic [3:0]       code_mem [2**AW];
    logic [DUR_W-1:0] dur_mem  [2**AW];
    logic [TW-1:0]    tick_cnt, tick_nxt;
    logic [DUR_W-1:0] dur_cnt, dur_nxt;
    logic [AW-1:0]    addr_nxt;
    logic [3:0]       pos_nxt;
    logic             en_nxt, done_nxt, end_now, wrap;

    assign busy = state != IDLE;
    assign wrap = tick_cnt == TW'(TICK_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            dur_cnt   <= '0;
            step_addr <= '0;
            pos_t     <= '0;
            pwm_en    <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 2**AW; i++) begin
                code_mem[i] <= '0;
                dur_mem[i]  <= '0;
            end
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            dur_cnt   <= dur_nxt;
            step_addr <= addr_nxt;
            pos_t     <= pos_nxt;
            pwm_en    <= en_nxt;
            done      <= done_nxt;
            if (wr_en) begin
                code_mem[wr_addr] <= wr_code;
                dur_mem[wr_addr]  <= wr_dur;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        dur_nxt   = dur_cnt;
        addr_nxt  = step_addr;
        pos_nxt   = pos_t;
        en_nxt    = pwm_en;
        done_nxt  = 1'b0;
        end_now   = 1'b0;
        case (state)
            IDLE: if (start && !stop) begin
                addr_nxt  = '0;
                state_nxt = FETCH;
            end
            FETCH: if (dur_mem[step_addr] == '0) begin
                end_now = 1'b1;
            end else begin
                pos_nxt   = code_mem[step_addr];
                en_nxt    = 1'b1;
                dur_nxt   = dur_mem[step_addr];
                tick_nxt  = '0;
                state_nxt = PLAY;
            end
            PLAY: begin
                tick_nxt = wrap ? '0 : tick_cnt + 1'b1;
                if (wrap) begin
                    dur_nxt = dur_cnt - 1'b1;
                    if (dur_cnt == DUR_W'(1)) begin
                        if (step_addr == last_addr) begin
                            end_now = 1'b1;
                        end else begin
                            addr_nxt  = step_addr + 1'b1;
                            state_nxt = FETCH;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // pwm_en is left high on a loop restart so the output is not interrupted
        if (end_now) begin
            if (loop_en) begin
                addr_nxt  = '0;
                state_nxt = FETCH;
            end else begin
                state_nxt = IDLE;
                en_nxt    = 1'b0;
                done_nxt  = 1'b1;
            end
        end
        if (stop && state != IDLE) begin
            state_nxt = IDLE;
            en_nxt    = 1'b0;
            done_nxt  = 1'b0;
        end
    end
endmodule

// File: tb/tb_pwm_tone_sequencer.sv
// tb_pwm_tone_sequencer: output-change scoreboard; each expected event carries
// the output snapshot and how many cycles the previous snapshot lasted.
module tb_pwm_tone_sequencer;
    logic       clk = 1'b0, rst_n = 1'b1;
    logic       wr_en = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [3:0] wr_addr = '0, wr_code = '0, last_addr = '0;
    logic [7:0] wr_dur = '0;
    logic [3:0] pos_t, step_addr;
    logic       pwm_en, busy, done;

    int errors = 0, checks = 0;

    typedef struct {
        logic [10:0] s;
        int          r;
    } ev_t;
    ev_t q[$];

    pwm_tone_sequencer #(.AW(4), .DUR_W(8), .TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_code(wr_code), .wr_dur(wr_dur), .start(start), .stop(stop),
        .loop_en(loop_en), .last_addr(last_addr), .pos_t(pos_t),
        .pwm_en(pwm_en), .busy(busy), .step_addr(step_addr), .done(done)
    );

    always #5 clk = ~clk;

    logic [10:0] cur, prev_s = '0;
    int          run_len = 0;
    ev_t         e;

    always @(negedge clk) begin
        cur = {done, busy, pwm_en, step_addr, pos_t};
        run_len++;
        if (cur !== prev_s) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got=%h after %0d cycles", cur, run_len);
            end else begin
                e = q.pop_front();
                if (cur !== e.s || (e.r >= 0 && run_len != e.r)) begin
                    errors++;
                    $display("FAIL event got=%h run=%0d want=%h run=%0d", cur, run_len, e.s, e.r);
                end
            end
            prev_s  = cur;
            run_len = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // snapshot order: done, busy, pwm_en, step_addr, pos_t; r<0 = length not checked
    task automatic ev(input logic d, b, en, input logic [3:0] a, p, input int r);
        q.push_back('{s: {d, b, en, a, p}, r: r});
    endtask

    task automatic wr(input logic [3:0] a, c, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_code = c; wr_dur = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout pending=%0d want=0", name, q.size());
            q.delete();
        end
    endtask

    task automatic chk(input string name, input logic [10:0] got, want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        step();
        chk("reset_outputs", {done, busy, pwm_en, step_addr, pos_t}, 11'h0);

        // empty table: end marker at first fetch
        ev(0, 1, 0, 0, 0, -1);
        ev(1, 0, 0, 0, 0, 1);
        ev(0, 0, 0, 0, 0, 1);
        pulse_start();
        drain("empty");

        // start and stop together in IDLE: nothing happens
        start = 1'b1; stop = 1'b1;
        repeat (3) step();
        start = 1'b0; stop = 1'b0;
        step();
        chk("start_stop_idle", {done, busy, pwm_en, step_addr, pos_t}, 11'h0);

        // basic one-shot
        wr(0, 3, 2);
        wr(1, 7, 1);
        last_addr = 1; loop_en = 0;
        ev(0, 1, 0, 0, 0, -1);
        ev(0, 1, 1, 0, 3, 1);
        ev(0, 1, 1, 1, 3, 8);
        ev(0, 1, 1, 1, 7, 1);
        ev(1, 0, 0, 1, 7, 4);
        ev(0, 0, 0, 1, 7, 1);
        pulse_start();
        drain("basic");

        // loop, then drop loop_en during the second pass
        loop_en = 1;
        ev(0, 1, 0, 0, 7, -1);
        ev(0, 1, 1, 0, 3, 1);
        ev(0, 1, 1, 1, 3, 8);
        ev(0, 1, 1, 1, 7, 1);
        ev(0, 1, 1, 0, 7, 4);
        ev(0, 1, 1, 0, 3, 1);
        ev(0, 1, 1, 1, 3, 8);
        ev(0, 1, 1, 1, 7, 1);
        ev(1, 0, 0, 1, 7, 4);
        ev(0, 0, 0, 1, 7, 1);
        pulse_start();
        repeat (19) step();
        loop_en = 0;
        drain("loop");

        // abort mid-play, then restart from entry 0
        wr(0, 3, 5);
        ev(0, 1, 0, 0, 7, -1);
        ev(0, 1, 1, 0, 3, 1);
        ev(0, 0, 0, 0, 3, 5);
        pulse_start();
        repeat (5) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("abort_idle", {done, busy, pwm_en}, 11'h0);
        drain("abort");
        ev(0, 1, 0, 0, 3, -1);
        ev(0, 1, 1, 0, 3, 1);
        ev(0, 1, 1, 1, 3, 20);
        ev(0, 1, 1, 1, 7, 1);
        ev(1, 0, 0, 1, 7, 4);
        ev(0, 0, 0, 1, 7, 1);
        pulse_start();
        drain("restart");

        // table writes while entry 0 plays
        wr(0, 3, 2);
        ev(0, 1, 0, 0, 7, -1);
        ev(0, 1, 1, 0, 3, 1);
        ev(0, 1, 1, 1, 3, 8);
        ev(0, 1, 1, 1, 12, 1);
        ev(1, 0, 0, 1, 12, 4);
        ev(0, 0, 0, 1, 12, 1);
        pulse_start();
        repeat (2) step();
        wr(0, 9, 1);
        wr(1, 12, 1);
        drain("write_play");

        // full table, loop, address wrap 15 -> 0, then async reset mid-play
        for (int i = 0; i < 16; i++) wr(4'(i), 4'(i), 1);
        last_addr = 15; loop_en = 1;
        ev(0, 1, 0, 0, 12, -1);
        ev(0, 1, 1, 0, 0, 1);
        for (int i = 1; i < 16; i++) begin
            ev(0, 1, 1, 4'(i), 4'(i - 1), 4);
            ev(0, 1, 1, 4'(i), 4'(i), 1);
        end
        ev(0, 1, 1, 0, 15, 4);
        ev(0, 1, 1, 0, 0, 1);
        ev(0, 0, 0, 0, 0, 2);
        pulse_start();
        repeat (83) step();
        rst_n = 1'b0;
        #1;
        chk("async_reset", {done, busy, pwm_en, step_addr, pos_t}, 11'h0);
        #1 rst_n = 1'b1;
        loop_en = 0;
        drain("wrap");

        // table must be cleared by the reset
        ev(0, 1, 0, 0, 0, -1);
        ev(1, 0, 0, 0, 0, 1);
        ev(0, 0, 0, 0, 0, 1);
        pulse_start();
        drain("cleared");
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
